// File: rtl/neuron_pkg.sv
// Shared definitions for the Q4.4 neuron datapath.
//   FRAC_BITS, Q44_MAX, Q44_MIN : Q4.4 format constants
//   state_t                     : MAC sequencing states
//   sat_round_q44_f             : round-half-up and saturate of a Q.8 sum to Q4.4
package neuron_pkg;

  localparam int FRAC_BITS = 4;
  localparam int Q44_MAX   = 127;
  localparam int Q44_MIN   = -128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Accepts a sign-extended Q.8 sum; the +8 before the shift is the
  // half-LSB of Q4.4, so ties round toward +inf.
  function automatic logic [7:0] sat_round_q44_f(input logic signed [31:0] acc);
    logic signed [31:0] r;
    r = (acc + 32'sd8) >>> FRAC_BITS;
    if (r > 32'(Q44_MAX))      return 8'h7f;
    else if (r < 32'(Q44_MIN)) return 8'h80;
    else                       return r[7:0];
  endfunction

endpackage

// File: rtl/sat_round_q44.sv
// Combinational round-half-up and saturate of an ACC_W-bit signed Q.8
// accumulator down to signed Q4.4.
//   acc : signed Q(ACC_W-8).8 sum
//   z   : signed Q4.4 result, clamped to [-128, 127]
module sat_round_q44
  import neuron_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [7:0]       z
);

  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(8);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(Q44_MAX);
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(Q44_MIN);

  // One guard bit so the rounding add cannot wrap at the top of the range.
  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  assign acc_x = {acc[ACC_W-1], acc};
  assign sum   = acc_x + RND;
  assign r     = sum >>> FRAC_BITS;

  always_comb begin
    z = r[7:0];
    if (r > MAXV)      z = 8'h7f;
    else if (r < MINV) z = 8'h80;
  end

endmodule

// File: rtl/neuron_mac_q44.sv
// Serial dot-product neuron: accumulates signed Q4.4 x*w pairs plus a Q4.4
// bias at full precision, then rounds/saturates to a Q4.4 pre-activation.
//   clk, rst_n        : clock, async active-low reset
//   flush             : synchronous abort of vector and pending output
//   in_valid/in_ready : pair handshake for x_in, w_in, bias_in, last_in
//   z_valid/z_ready   : result handshake for z_out, term_ovf
//   term_ovf          : vector ended by MAX_TERMS rather than last_in
//
// state | meaning
// IDLE  | waiting for the first pair; bias is sampled with it
// ACC   | accumulating further pairs
// FIN   | one cycle: round/saturate accumulator into z_out
// OUT   | result presented until z_ready
module neuron_mac_q44
  import neuron_pkg::*;
#(
  parameter int ACC_W     = 20,
  parameter int MAX_TERMS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x_in,
  input  logic signed [7:0] w_in,
  input  logic signed [7:0] bias_in,
  input  logic              last_in,
  output logic              z_valid,
  input  logic              z_ready,
  output logic        [7:0] z_out,
  output logic              term_ovf
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [7:0]        z_out_q, z_out_d;
  logic                     z_valid_q, z_valid_d;
  logic                     ovf_q, ovf_d;

  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic        [7:0]        z_sat;
  logic                     accept;

  assign prod     = x_in * w_in;
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  // Q4.4 bias aligned to the Q.8 accumulator.
  assign bias_ext = {{(ACC_W-12){bias_in[7]}}, bias_in, 4'b0000};

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign accept   = in_valid && in_ready;

  sat_round_q44 #(.ACC_W(ACC_W)) u_sat (
    .acc (acc_q),
    .z   (z_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      z_out_q   <= '0;
      z_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      z_out_q   <= z_out_d;
      z_valid_q <= z_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    z_out_d   = z_out_q;
    z_valid_d = z_valid_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d = bias_ext + prod_ext;
          cnt_d = CNT_ONE;
          if (last_in || MAX_TERMS == 1) begin
            state_d = ST_FIN;
            ovf_d   = !last_in;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + CNT_ONE;
          if (last_in || (cnt_q + CNT_ONE) == CNT_MAX) begin
            state_d = ST_FIN;
            ovf_d   = !last_in;
          end
        end
      end
      ST_FIN: begin
        z_out_d   = z_sat;
        z_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (z_ready) begin
          z_valid_d = 1'b0;
          ovf_d     = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // z_out deliberately keeps its last value across a flush.
    if (flush) begin
      state_d   = ST_IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      z_valid_d = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  assign z_out    = z_out_q;
  assign z_valid  = z_valid_q;
  assign term_ovf = ovf_q;

endmodule

// File: tb/tb_neuron_mac_q44.sv
module tb_neuron_mac_q44;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_in;
  logic signed [7:0] w_in;
  logic signed [7:0] bias_in;
  logic              last_in;
  logic              z_valid;
  logic              z_ready;
  logic        [7:0] z_out;
  logic              term_ovf;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] xs [16];
  logic [7:0] ws [16];

  neuron_mac_q44 #(.ACC_W(20), .MAX_TERMS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias_in  (bias_in),
    .last_in  (last_in),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z_out    (z_out),
    .term_ovf (term_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n pairs from xs/ws, checks FIN->valid latency, result and flag.
  // With hold set, in_valid stays high after the vector to probe in_ready.
  task automatic run_vec(input string tag, input logic [7:0] b, input int n,
                         input bit use_last, input bit hold,
                         input logic [7:0] exp_z, input bit exp_ovf);
    int k;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      x_in     = xs[i];
      w_in     = ws[i];
      bias_in  = b;
      last_in  = use_last && (i == n - 1);
      step();
    end
    in_valid = hold;
    last_in  = 1'b0;
    chk({tag, "_fin"}, 32'(z_valid), 32'd0);
    k = 0;
    while (!z_valid && k < 4) begin
      if (hold) chk({tag, "_rdy_fin"}, 32'(in_ready), 32'd0);
      step();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'd1);
    if (hold) chk({tag, "_rdy_out"}, 32'(in_ready), 32'd0);
    chk({tag, "_z"}, 32'(z_out), 32'(exp_z));
    chk({tag, "_ovf"}, 32'(term_ovf), 32'(exp_ovf));
    in_valid = 1'b0;
    if (z_ready) begin
      step();
      chk({tag, "_done"}, 32'(z_valid), 32'd0);
    end
  endtask

  task automatic set1(input logic [7:0] x, input logic [7:0] w);
    xs[0] = x;
    ws[0] = w;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; x_in = '0; w_in = '0;
    bias_in = '0; last_in = 1'b0; z_ready = 1'b1;
    #12;
    chk("rst_z", 32'(z_out), 32'd0);
    chk("rst_valid", 32'(z_valid), 32'd0);
    chk("rst_ovf", 32'(term_ovf), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    step();

    set1(8'd16, 8'd16);
    run_vec("one", 8'd0, 1, 1'b1, 1'b0, 8'd16, 1'b0);

    // Reset in the middle of an accumulation clears z_out immediately.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_in = 8'sd127; w_in = 8'sd127; bias_in = 8'sd0; last_in = 1'b0;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_z", 32'(z_out), 32'd0);
    chk("mid_rst_valid", 32'(z_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    step();
    set1(8'd16, 8'd16);
    run_vec("post_rst", 8'd0, 1, 1'b1, 1'b0, 8'd16, 1'b0);

    set1(8'd16, 8'hF0);
    run_vec("bias", 8'd32, 1, 1'b1, 1'b0, 8'd16, 1'b0);

    set1(8'd1, 8'd8);   run_vec("rnd_p8", 8'd0, 1, 1'b1, 1'b0, 8'd1, 1'b0);
    set1(8'd1, 8'd7);   run_vec("rnd_p7", 8'd0, 1, 1'b1, 1'b0, 8'd0, 1'b0);
    set1(8'hFF, 8'd8);  run_vec("rnd_m8", 8'd0, 1, 1'b1, 1'b0, 8'd0, 1'b0);
    set1(8'hFF, 8'd9);  run_vec("rnd_m9", 8'd0, 1, 1'b1, 1'b0, 8'hFF, 1'b0);

    for (int i = 0; i < 4; i++) begin xs[i] = 8'd127; ws[i] = 8'd127; end
    run_vec("sat_pos", 8'd0, 4, 1'b1, 1'b0, 8'h7F, 1'b0);
    for (int i = 0; i < 2; i++) begin xs[i] = 8'h80; ws[i] = 8'd127; end
    run_vec("sat_neg", 8'd0, 2, 1'b1, 1'b0, 8'h80, 1'b0);

    // bias -1.0 + 3 * (2.0*0.5) = 2.0
    for (int i = 0; i < 3; i++) begin xs[i] = 8'd32; ws[i] = 8'd8; end
    run_vec("multi", 8'hF0, 3, 1'b1, 1'b0, 8'd32, 1'b0);

    for (int i = 0; i < 16; i++) begin xs[i] = 8'd16; ws[i] = 8'd1; end
    run_vec("maxterm", 8'd0, 16, 1'b0, 1'b1, 8'd16, 1'b1);

    // Backpressure: result and in_ready held while z_ready is low.
    z_ready = 1'b0;
    set1(8'd32, 8'd16);
    run_vec("bp", 8'd0, 1, 1'b1, 1'b0, 8'd32, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_z", 32'(z_out), 32'd32);
      chk("bp_hold_valid", 32'(z_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    z_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(z_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Flush in OUT discards the result but keeps z_out.
    z_ready = 1'b0;
    set1(8'd48, 8'd16);
    run_vec("fl_out", 8'd0, 1, 1'b1, 1'b0, 8'd48, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_out_valid", 32'(z_valid), 32'd0);
    chk("fl_out_zkeep", 32'(z_out), 32'd48);
    chk("fl_out_ready", 32'(in_ready), 32'd1);
    z_ready = 1'b1;
    set1(8'd1, 8'd8);
    run_vec("fl_out_next", 8'd0, 1, 1'b1, 1'b0, 8'd1, 1'b0);

    // Flush in ACC with a same-cycle last pair: nothing is produced.
    in_valid = 1'b1; x_in = 8'd16; w_in = 8'd16; bias_in = 8'd0; last_in = 1'b0;
    step();
    x_in = 8'd127; w_in = 8'd127; last_in = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; last_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fl_acc_novalid", 32'(z_valid), 32'd0);
      step();
    end
    set1(8'd1, 8'd7);
    run_vec("fl_acc_next", 8'd0, 1, 1'b1, 1'b0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_mac_q44.md
Name: neuron_mac_q44

Overview:
Serial dot-product neuron that produces the Q4.4 pre-activation consumed by the 8-bit sigmoid stage.
- Accepts one signed Q4.4 input/weight pair per cycle plus a Q4.4 bias.
- Accumulates at full precision, then rounds and saturates the sum to signed Q4.4.
- Presents the result on a valid/ready output port; z_out drives the sigmoid input bus directly.

Parameters:
- ACC_W, 20, accumulator width in bits (signed Q(ACC_W-8).8); must be >= 16 + ceil(log2(MAX_TERMS)).
- MAX_TERMS, 16, maximum pairs per vector; the MAX_TERMS-th pair is forced to act as last.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous abort of the current vector/output
- in_valid  in  1  pair valid
- in_ready  out  1  pair accepted when in_valid & in_ready at clk rise
- x_in  in  8  signed Q4.4 input
- w_in  in  8  signed Q4.4 weight
- bias_in  in  8  signed Q4.4 bias; sampled only with the first pair of a vector
- last_in  in  1  marks the final pair of a vector
- z_valid  out  1  result valid
- z_ready  in  1  downstream accepts the result
- z_out  out  8  signed Q4.4 saturated pre-activation
- term_ovf  out  1  result was terminated by MAX_TERMS, not by last_in; qualified by z_valid

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous assert, active-low; release is synchronous to clk.
- Reset values: state=IDLE, acc=0, term count=0, z_out=0, z_valid=0, term_ovf=0, in_ready=1.
- States: IDLE, ACC, FIN, OUT. in_ready = 1 in IDLE or ACC, else 0.
- Product: x_in*w_in is a signed 16-bit Q8.8 value, sign-extended to ACC_W.
- IDLE, accept:
  - acc <= (sext(bias_in) <<< 4) + product; count <= 1.
  - Go to FIN if last_in or MAX_TERMS==1, else ACC.
- ACC, accept:
  - acc <= acc + product; count++.
  - Go to FIN if last_in or count+1==MAX_TERMS.
  - term_ovf latched 1 when termination is by count with last_in=0.
- ACC with no handshake: hold all state; no timeout.
- FIN, exactly one cycle:
  - r = (acc + 8) >>> 4, i.e. round half up toward +inf.
  - Saturate: z_out <= 127 if r>127, -128 if r<-128, else r[7:0].
  - z_valid <= 1; go to OUT.
- OUT:
  - Hold z_out, z_valid, term_ovf stable while z_ready=0.
  - On z_ready=1: z_valid <= 0, term_ovf <= 0, go to IDLE.
  - A new vector is accepted from the next cycle (no bypass).
- Latency: last pair accepted at edge t; z_valid=1 after edge t+1.
- Throughput: N+2 cycles per N-pair vector with z_ready held high.
- flush=1 (any state): next state IDLE, acc=0, count=0, z_valid=0, term_ovf=0.
  - A same-cycle input pair is dropped.
  - A pending output is discarded.
  - z_out keeps its last value.
- Accumulator never wraps, given the parameter constraint on ACC_W.
- Reset mid-vector or mid-output: immediate return to reset values; the partial vector is lost.

Decomposition:
- Shared package (neuron_pkg): Q4.4 constants FRAC_BITS=4, Q44_MAX=127, Q44_MIN=-128; state enum typedef; saturate/round function reused by later layers.
- Sub-module sat_round_q44: parameterised ACC_W to 8-bit round-half-up and saturate, combinational, used in FIN.

Test Plan:
1. Reset mid-ACC (rst_n low, async) -> all outputs at reset values immediately; first vector after release computes correctly.
2. Single pair x=16, w=16, bias=0, last=1 -> z_out=16 (1.0) two cycles after accept; term_ovf=0. Bias=32, x=16, w=-16 -> z_out=16.
3. Rounding: x=1, w=8 -> z_out=1; x=1, w=7 -> z_out=0; x=-1, w=8 -> z_out=0; x=-1, w=9 -> z_out=-1 (0xFF).
4. Saturation: 4 pairs 127*127, bias=0 -> z_out=127; 2 pairs -128*127 -> z_out=-128 (0x80).
5. MAX_TERMS=16: 16 pairs 16*1, last never set -> z_valid after 16th; z_out=16; term_ovf=1; 17th pair not accepted (in_ready=0).
6. Backpressure/flush: z_ready=0 for 5 cycles -> z_out stable, in_ready=0. Flush in OUT -> z_valid=0 and next vector accepted. Flush with in_valid in ACC -> pair dropped, no output.
